// File: rtl/alu_operand_sequencer.sv
// Operand/opcode capture front-end and result capture back-end for the lab-board ALU.
// One field is loaded per button press; the ALU result is latched one cycle after execute.
module alu_operand_sequencer #(
    parameter int unsigned ANCHO = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [ANCHO-1:0] sw_data_i,
    input  logic             sw_flag_i,
    input  logic             btn_i,
    input  logic [ANCHO-1:0] alu_result_i,
    input  logic             alu_flag_i,
    input  logic             alu_zero_i,
    output logic [ANCHO-1:0] alu_a_o,
    output logic [ANCHO-1:0] alu_b_o,
    output logic [3:0]       alu_control_o,
    output logic             alu_flagin_o,
    output logic [ANCHO-1:0] result_o,
    output logic             flag_o,
    output logic             zero_o,
    output logic             valid_o,
    output logic             err_o,
    output logic [2:0]       state_o
);

    localparam logic [2:0] LOAD_A  = 3'd0;
    localparam logic [2:0] LOAD_B  = 3'd1;
    localparam logic [2:0] LOAD_OP = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] SHOW    = 3'd4;

    localparam logic [3:0] MAX_OPCODE = 4'h9;

    // Button synchroniser (s1, s2) plus delay flop s3 for rising-edge detection.
    logic btn_s1;
    logic btn_s2;
    logic btn_s3;
    logic press;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            btn_s3 <= 1'b0;
        end else begin
            btn_s1 <= btn_i;
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
        end
    end

    assign press = btn_s2 & ~btn_s3;

    logic [2:0]       state_q,   state_d;
    logic [ANCHO-1:0] a_q,       a_d;
    logic [ANCHO-1:0] b_q,       b_d;
    logic [3:0]       op_q,      op_d;
    logic             flagin_q,  flagin_d;
    logic [ANCHO-1:0] result_q,  result_d;
    logic             flag_q,    flag_d;
    logic             zero_q,    zero_d;
    logic             valid_q,   valid_d;
    logic             err_q,     err_d;
    logic [3:0]       sw_opcode;

    assign sw_opcode = sw_data_i[3:0];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        flagin_d = flagin_q;
        result_d = result_q;
        flag_d   = flag_q;
        zero_d   = zero_q;
        valid_d  = valid_q;
        err_d    = err_q;

        case (state_q)
            LOAD_A: begin
                if (press) begin
                    a_d     = sw_data_i;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press) begin
                    b_d     = sw_data_i;
                    state_d = LOAD_OP;
                end
            end
            LOAD_OP: begin
                if (press) begin
                    if (sw_opcode <= MAX_OPCODE) begin
                        op_d     = sw_opcode;
                        flagin_d = sw_flag_i;
                        err_d    = 1'b0;
                        state_d  = EXEC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                // ALU inputs have been stable for the whole cycle; presses here are dropped.
                result_d = alu_result_i;
                flag_d   = alu_flag_i;
                zero_d   = alu_zero_i;
                valid_d  = 1'b1;
                state_d  = SHOW;
            end
            SHOW: begin
                if (press) begin
                    valid_d = 1'b0;
                    state_d = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            flagin_q <= 1'b0;
            result_q <= '0;
            flag_q   <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            flagin_q <= flagin_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign alu_control_o = op_q;
    assign alu_flagin_o  = flagin_q;
    assign result_o      = result_q;
    assign flag_o        = flag_q;
    assign zero_o        = zero_q;
    assign valid_o       = valid_q;
    assign err_o         = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer with a behavioural ALU attached.
// Expected values come from a transaction-level model of the load/execute/show cycle.
module tb_alu_operand_sequencer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_data = '0;
    logic         sw_flag = 1'b0;
    logic         btn = 1'b0;
    logic [W-1:0] alu_result;
    logic         alu_flag;
    logic         alu_zero;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_control;
    logic         alu_flagin;
    logic [W-1:0] result;
    logic         flag;
    logic         zero;
    logic         valid;
    logic         err;
    logic [2:0]   state;

    int tests = 0;
    int fails = 0;

    // Model state (spec-level: phase number, fields, display registers).
    int           m_st = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [3:0]   m_op = '0;
    logic         m_cin = 1'b0, m_flg = 1'b0, m_zero = 1'b0, m_valid = 1'b0, m_err = 1'b0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.ANCHO(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sw_data_i    (sw_data),
        .sw_flag_i    (sw_flag),
        .btn_i        (btn),
        .alu_result_i (alu_result),
        .alu_flag_i   (alu_flag),
        .alu_zero_i   (alu_zero),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_control_o(alu_control),
        .alu_flagin_o (alu_flagin),
        .result_o     (result),
        .flag_o       (flag),
        .zero_o       (zero),
        .valid_o      (valid),
        .err_o        (err),
        .state_o      (state)
    );

    // Returns {flag, result}.
    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] op, input logic cin);
        logic [4:0] r;
        case (op)
            4'h0:    r = {1'b0, a & b};
            4'h1:    r = {1'b0, a | b};
            4'h2:    r = {1'b0, a} + {1'b0, b} + {4'b0, cin};
            4'h3:    r = {(a < b), a - b};
            4'h4:    r = {1'b0, a ^ b};
            4'h5:    r = {1'b0, ~(a | b)};
            4'h6:    r = {a[3], a[2:0], 1'b0};
            4'h7:    r = {a[0], 1'b0, a[3:1]};
            4'h8:    r = {1'b0, ~(a & b)};
            4'h9:    r = {1'b0, a};
            default: r = 5'b0;
        endcase
        return r;
    endfunction

    logic [4:0] alu_out;
    always_comb begin
        alu_out    = alu_fn(alu_a, alu_b, alu_control, alu_flagin);
        alu_result = alu_out[3:0];
        alu_flag   = alu_out[4];
        alu_zero   = (alu_out[3:0] == 4'h0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "/state"},  {29'b0, state},       m_st);
        chk({tag, "/a"},      {28'b0, alu_a},       {28'b0, m_a});
        chk({tag, "/b"},      {28'b0, alu_b},       {28'b0, m_b});
        chk({tag, "/op"},     {28'b0, alu_control}, {28'b0, m_op});
        chk({tag, "/flagin"}, {31'b0, alu_flagin},  {31'b0, m_cin});
        chk({tag, "/result"}, {28'b0, result},      {28'b0, m_res});
        chk({tag, "/flag"},   {31'b0, flag},        {31'b0, m_flg});
        chk({tag, "/zero"},   {31'b0, zero},        {31'b0, m_zero});
        chk({tag, "/valid"},  {31'b0, valid},       {31'b0, m_valid});
        chk({tag, "/err"},    {31'b0, err},         {31'b0, m_err});
    endtask

    task automatic model_reset();
        m_st = 0; m_a = '0; m_b = '0; m_op = '0; m_cin = 0;
        m_res = '0; m_flg = 0; m_zero = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic model_press(input logic [W-1:0] d, input logic f);
        case (m_st)
            0: begin m_a = d; m_st = 1; end
            1: begin m_b = d; m_st = 2; end
            2: begin
                if (d[3:0] <= 4'h9) begin
                    m_op = d[3:0]; m_cin = f; m_err = 0; m_st = 3;
                end else begin
                    m_err = 1;
                end
            end
            4: begin m_valid = 0; m_st = 0; end
            default: ;
        endcase
    endtask

    task automatic model_exec();
        logic [4:0] r;
        r = alu_fn(m_a, m_b, m_op, m_cin);
        m_res = r[3:0]; m_flg = r[4]; m_zero = (r[3:0] == 4'h0);
        m_valid = 1; m_st = 4;
    endtask

    // Raise the button before edge k; commit lands on edge k+2.
    task automatic press(input logic [W-1:0] d, input logic f, input string tag);
        @(negedge clk);
        sw_data = d; sw_flag = f; btn = 1'b1;
        @(posedge clk); #1 chk_all({tag, "/k"});
        @(posedge clk); #1 chk_all({tag, "/k1"});
        @(posedge clk); #1;
        model_press(d, f);
        chk_all({tag, "/commit"});
        if (m_st == 3) begin
            @(negedge clk);
            sw_data = W'($urandom);   // must not reach the ALU registers
            @(posedge clk); #1;
            model_exec();
            chk_all({tag, "/show"});
        end
        @(negedge clk);
        btn = 1'b0;
        sw_data = W'($urandom);
        repeat (3) @(posedge clk);
        #1 chk_all({tag, "/idle"});
    endtask

    initial begin
        int first_move;
        int changes;
        logic [2:0] prev;

        // Reset then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 model_reset();
        chk_all("reset");
        @(negedge clk) rst = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk_all("idle");

        // Add path: 5 + 3 + 1 = 9
        press(4'h5, 1'b0, "add_a");
        press(4'h3, 1'b0, "add_b");
        press(4'h2, 1'b1, "add_op");
        chk("add_result", {28'b0, result}, 32'h9);
        chk("add_state", {29'b0, state}, 32'd4);
        press(4'h0, 1'b0, "add_ack");

        // Zero result: 0xA & 0x5
        press(4'hA, 1'b0, "zero_a");
        press(4'h5, 1'b0, "zero_b");
        press(4'h0, 1'b0, "zero_op");
        chk("zero_flag", {31'b0, zero}, 32'd1);
        press(4'h0, 1'b0, "zero_ack");

        // Bad opcode then good opcode
        press(4'h6, 1'b0, "bad_a");
        press(4'h9, 1'b0, "bad_b");
        press(4'hC, 1'b1, "bad_op");
        chk("bad_err", {31'b0, err}, 32'd1);
        press(4'h7, 1'b0, "good_op");
        press(4'h0, 1'b0, "good_ack");

        // Held button in LOAD_A: one move, two edges after the first synchronised sample
        @(negedge clk);
        sw_data = 4'hB; btn = 1'b1;
        first_move = -1; changes = 0; prev = state;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (state !== prev) begin
                changes++;
                if (first_move < 0) first_move = i;
            end
            prev = state;
        end
        model_press(4'hB, 1'b0);
        chk("hold_moves", changes, 1);
        chk("hold_edge", first_move, 3);
        chk_all("hold_end");
        @(negedge clk) btn = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_all("hold_rel");

        // Reset mid-EXEC with A=0xF
        rst = 1'b1;
        @(posedge clk); #1 model_reset();
        @(negedge clk) rst = 1'b0;
        press(4'hF, 1'b0, "rst_a");
        press(4'h1, 1'b0, "rst_b");
        @(negedge clk);
        sw_data = 4'h2; btn = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("rst_exec", {29'b0, state}, 32'd3);
        rst = 1'b1; btn = 1'b0;
        @(posedge clk); #1 model_reset();
        chk_all("rst_mid");
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk_all("rst_after");

        // Randomized full cycles, occasionally with rejected opcodes
        for (int n = 0; n < 25; n++) begin
            press(W'($urandom), 1'($urandom), "rnd_a");
            press(W'($urandom), 1'($urandom), "rnd_b");
            if ($urandom_range(0, 2) == 0)
                press(W'($urandom_range(10, 15)), 1'($urandom), "rnd_bad");
            press(W'($urandom_range(0, 9)), 1'($urandom), "rnd_op");
            press(W'($urandom), 1'($urandom), "rnd_ack");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
